rst_release_seq: RTL and testbench

RST_RELEASE_SEQ -- requirements
Module: rst_release_seq

---
 rtl/rst_release_seq.sv | 122 ++++++++++++
 tb/tb_rst_release_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_release_seq.sv
// Reset release sequencer: synchronizes a soft-reset request, stretches the release by HOLD_CYC
// cycles and drives a glitch-free registered reset plus a settled flag. Optional macro: RST_SEQ_RELCNT_EN.
module rst_release_seq #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             SRSTN,
   input  logic [CNT_W-1:0] HOLD_CYC,
   output logic             RSTB_OUT,
   output logic             READY,
   output logic [1:0]       STATE
`ifdef RST_SEQ_RELCNT_EN
  ,output logic [7:0]       REL_CNT
`endif
);

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rstb_out_q, rstb_out_d;
   logic                   ready_q, ready_d;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], SRSTN};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rstb_out_d = rstb_out_q;
      ready_d    = ready_q;
      case (state_q)
         ST_HOLD: begin
            rstb_out_d = 1'b0;
            ready_d    = 1'b0;
            if (sync_out) begin
               state_d = ST_COUNT;
               cnt_d   = HOLD_CYC;
            end
         end
         ST_COUNT: begin
            rstb_out_d = 1'b0;
            ready_d    = 1'b0;
            if (!sync_out) begin
               state_d = ST_HOLD;
            end else if (cnt_q == '0) begin
               state_d    = ST_RUN;
               rstb_out_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RUN: begin
            // READY trails RSTB_OUT by one edge because it only sets once already in RUN
            if (!sync_out) begin
               state_d    = ST_HOLD;
               rstb_out_d = 1'b0;
               ready_d    = 1'b0;
            end else begin
               rstb_out_d = 1'b1;
               ready_d    = 1'b1;
            end
         end
         default: begin
            state_d    = ST_HOLD;
            rstb_out_d = 1'b0;
            ready_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         rstb_out_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rstb_out_q <= rstb_out_d;
         ready_q    <= ready_d;
      end
   end

   assign RSTB_OUT = rstb_out_q;
   assign READY    = ready_q;
   assign STATE    = state_q;

`ifdef RST_SEQ_RELCNT_EN
   logic       rel_inc;
   logic [7:0] rel_q;

   assign rel_inc = (state_q == ST_COUNT) && (state_d == ST_RUN);

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         rel_q <= '0;
      end else if (rel_inc && (rel_q != 8'hFF)) begin
         rel_q <= rel_q + 8'd1;
      end
   end

   assign REL_CNT = rel_q;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// Self-checking bench for rst_release_seq: directed release scenarios plus randomized soft/hard
// resets compared every cycle against a run-length model of the release rules.
module tb_rst_release_seq;

   localparam int SS = 2;
   localparam int CW = 8;

   logic          CLK = 1'b0;
   logic          RSTB = 1'b1;
   logic          SRSTN = 1'b1;
   logic [CW-1:0] HOLD_CYC = 8'd3;
   logic          RSTB_OUT;
   logic          READY;
   logic [1:0]    STATE;
`ifdef RST_SEQ_RELCNT_EN
   logic [7:0]    REL_CNT;
`endif

   rst_release_seq #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .CLK      (CLK),
      .RSTB     (RSTB),
      .SRSTN    (SRSTN),
      .HOLD_CYC (HOLD_CYC),
      .RSTB_OUT (RSTB_OUT),
      .READY    (READY),
      .STATE    (STATE)
`ifdef RST_SEQ_RELCNT_EN
     ,.REL_CNT  (REL_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the released view of SRSTN is the raw input delayed SS edges. m_len counts consecutive
   // edges that saw it high; the outputs follow from m_len against the HOLD_CYC captured at its start.
   bit m_q[$];
   int m_len;
   int m_hold;
   int m_rel;

   task automatic m_reset();
      m_len  = 0;
      m_hold = 0;
      m_rel  = 0;
      m_q.delete();
      for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
   endtask

   task automatic m_step();
      bit seen;
      seen = m_q.pop_front();
      m_q.push_back(SRSTN);
      if (seen) begin
         m_len++;
         if (m_len == 1) m_hold = int'(HOLD_CYC);
         if (m_len == m_hold + 2 && m_rel < 255) m_rel++;
      end else begin
         m_len = 0;
      end
   endtask

   function automatic int exp_state();
      if (m_len == 0) return 0;
      if (m_len <= m_hold + 1) return 1;
      return 2;
   endfunction

   initial begin
      m_reset();
      forever begin
         @(posedge CLK or negedge RSTB);
         if (!RSTB) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         chk("model_state", int'(STATE), exp_state());
         chk("model_rstb_out", int'(RSTB_OUT), int'(m_len >= m_hold + 2));
         chk("model_ready", int'(READY), int'(m_len >= m_hold + 3));
`ifdef RST_SEQ_RELCNT_EN
         chk("model_rel_cnt", int'(REL_CNT), m_rel);
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic power_release(input int h, input int rise);
      HOLD_CYC = CW'(h);
      SRSTN    = 1'b1;
      RSTB     = 1'b0;
      tick();
      tick();
      @(negedge CLK);
      #1 RSTB = 1'b1;
      for (int e = 1; e <= rise + 1; e++) begin
         tick();
         chk("por_rstb_out", int'(RSTB_OUT), int'(e >= rise));
         chk("por_ready", int'(READY), int'(e >= rise + 1));
         chk("por_state", int'(STATE), (e <= SS) ? 0 : ((e < rise) ? 1 : 2));
      end
   endtask

   initial begin
      #1 RSTB = 1'b0;
      #1;
      chk("reset_rstb_out", int'(RSTB_OUT), 0);
      chk("reset_ready", int'(READY), 0);
      chk("reset_state", int'(STATE), 0);

      power_release(3, 7);
      power_release(0, 4);

      // Soft reset while running, HOLD_CYC=2, SRSTN low for one sampled edge
      HOLD_CYC = 8'd2;
      tick();
      SRSTN = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 1) SRSTN = 1'b1;
         chk("soft_rstb_out", int'(RSTB_OUT), int'(e < 3 || e >= 7));
         chk("soft_ready", int'(READY), int'(e < 3 || e >= 8));
      end

      // Hard reset between edges while running
      #3 RSTB = 1'b0;
      #1;
      chk("async_run_rstb_out", int'(RSTB_OUT), 0);
      chk("async_run_ready", int'(READY), 0);
      chk("async_run_state", int'(STATE), 0);

      // Soft reset during COUNT with HOLD_CYC=5; a mid-count HOLD_CYC change is ignored
      power_release(5, 9);
      HOLD_CYC = 8'd5;
      RSTB = 1'b0;
      tick();
      RSTB = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      chk("abort_pre_state", int'(STATE), 1);
      SRSTN = 1'b0;
      for (int e = 5; e <= 15; e++) begin
         tick();
         if (e == 5) SRSTN = 1'b1;
         if (e == 8) HOLD_CYC = 8'd1;
         chk("abort_state", int'(STATE), (e == 7) ? 0 : ((e <= 13) ? 1 : 2));
      end

      // Hard reset between edges during COUNT
      HOLD_CYC = 8'd5;
      RSTB = 1'b0;
      tick();
      RSTB = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      chk("async_cnt_pre_state", int'(STATE), 1);
      #3 RSTB = 1'b0;
      #1;
      chk("async_cnt_rstb_out", int'(RSTB_OUT), 0);
      chk("async_cnt_state", int'(STATE), 0);
      tick();
      RSTB = 1'b1;

      // Randomized soft/hard resets and HOLD_CYC changes; the per-cycle compare does the checking
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(0, 2) == 0)
            HOLD_CYC = ($urandom_range(0, 49) == 0) ? 8'd40 : CW'($urandom_range(0, 6));
         if (SRSTN) begin
            if ($urandom_range(0, 24) == 0) SRSTN = 1'b0;
         end else begin
            if ($urandom_range(0, 2) == 0) SRSTN = 1'b1;
         end
         if ($urandom_range(0, 399) == 0) begin
            RSTB = 1'b0;
            #1;
            chk("rand_async_rstb_out", int'(RSTB_OUT), 0);
            chk("rand_async_state", int'(STATE), 0);
            tick();
            RSTB = 1'b1;
         end
      end

`ifdef RST_SEQ_RELCNT_EN
      power_release(0, 4);
      chk("rel_cnt_por", int'(REL_CNT), 1);
      for (int r = 0; r < 3; r++) begin
         SRSTN = 1'b0;
         tick();
         SRSTN = 1'b1;
         for (int w = 0; w < 10; w++) tick();
      end
      chk("rel_cnt_three", int'(REL_CNT), 4);
      for (int r = 0; r < 300; r++) begin
         SRSTN = 1'b0;
         tick();
         SRSTN = 1'b1;
         for (int w = 0; w < 8; w++) tick();
      end
      chk("rel_cnt_sat", int'(REL_CNT), 255);
      #2 RSTB = 1'b0;
      #1;
      chk("rel_cnt_clear", int'(REL_CNT), 0);
      tick();
      RSTB = 1'b1;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
